mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single unified memory of the multi-cycle MIPS core between two requesters.
- Requester 1: the CPU datapath, covering both instruction fetch and data access.
- Requester 2: an external loader/DMA port used for program load and debug.
- Serialises single-word transactions, handles the memory's fixed read latency, and returns one-cycle acknowledges.
- Fixed priority to CPU, with a starvation bound for the external port.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles, legal range 1..7.
- STARVE_MAX, 4, number of consecutive CPU grants while ext_req is pending before EXT is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_adr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data, registered.
- cpu_ack  out  1  one-cycle completion pulse.
- ext_req, ext_we, ext_adr, ext_wdata, ext_rdata, ext_ack: same as the cpu_* ports, for the external port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_adr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset state:
  - state=IDLE.
  - All ack, mem_en and mem_we = 0.
  - mem_adr/mem_wdata = 0.
  - cpu_rdata and ext_rdata = 0.
  - starve_cnt = 0.
- Reset mid-transaction: the transaction is dropped with no ack. The requester must reissue.
- Requester protocol:
  - req, we, adr and wdata stay stable from assertion until the cycle after ack.
  - The requester drops req (or presents a new request) only after sampling ack=1.
  - The arbiter never samples req during RESP.
- FSM states:
  - IDLE: at each edge, if any req, pick a winner, latch winner id, we, adr and wdata → ISSUE. Otherwise stay.
  - ISSUE: exactly one cycle. mem_en=1, mem_we=latched we, mem_adr/mem_wdata = latched values.
    - Write → RESP.
    - Read → WAIT, with lat_cnt = MEM_LAT-1.
  - WAIT: mem_en=0. If lat_cnt==0, capture mem_rdata into the winner's rdata register → RESP. Else decrement lat_cnt.
  - RESP: winner's ack=1 for exactly one cycle → IDLE.
- Latency, counting from the IDLE edge that samples req:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+MEM_LAT.
  - Back-to-back throughput: one transaction per (3+MEM_LAT) cycles for reads, 3 cycles for writes. IDLE is always one cycle between transactions.
- Arbitration, fixed priority plus starvation bound:
  - Only one requester pending → it wins.
  - Both pending → CPU wins unless starve_cnt==STARVE_MAX, in which case EXT wins.
  - starve_cnt increments (saturating at STARVE_MAX) on each CPU grant made while ext_req=1.
  - starve_cnt clears on any EXT grant, and in any IDLE cycle where ext_req=0.
- rdata registers:
  - Hold their value until the next read completion for the same port.
  - Are untouched by writes and by the other port's transactions.
- mem_we is asserted only in ISSUE. No mem_en while in WAIT or RESP.

Optional Feature:
- MEMARB_RR_EN defined:
  - When both requesters are pending, arbitration is strict round-robin: the port not granted last wins.
  - A last_grant register resets to EXT, so the CPU wins the first tie.
  - starve_cnt logic is omitted and STARVE_MAX is ignored.
- MEMARB_RR_EN undefined: fixed priority with starvation bound, as described under Behaviour.

Test Plan:
- Reset held 2 cycles, then CPU read adr=0x00, memory model returns 0x20020005, MEM_LAT=1 → mem_en high in exactly one cycle with mem_adr=0x00; cpu_ack pulses 3 cycles after the sampling edge; cpu_rdata=0x20020005; ext_ack stays 0.
- EXT write adr=0x54, wdata=0x00000007 → single mem_en/mem_we cycle with mem_adr=0x54, mem_wdata=7; ext_ack 2 cycles later; subsequent CPU read of 0x54 returns 7.
- Both requesters held continuously, STARVE_MAX=4, CPU re-requesting immediately after each ack → grant order CPU,CPU,CPU,CPU,EXT,CPU…; with MEMARB_RR_EN → CPU,EXT,CPU,EXT.
- MEM_LAT=3, CPU read → cpu_ack exactly 5 cycles after the sampling edge; mem_en low during the 3 WAIT cycles.
- Reset asserted during WAIT of an EXT read → no ext_ack; all outputs 0 the cycle after reset; ext_rdata=0; a reissued EXT read completes normally.
- EXT read returning 0xDEADBEEF followed by a CPU read returning 0x12345678 → ext_rdata still 0xDEADBEEF; cpu_rdata=0x12345678.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises single-word accesses from the CPU datapath and
// the external loader/DMA port onto one unified memory with fixed read latency.
// Default build: fixed CPU priority with a starvation bound for the EXT port.
// Build macro MEMARB_RR_EN: strict round-robin tie-break instead (STARVE_MAX unused).
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_adr,
    input  logic [DW-1:0] ext_wdata,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    state_t        state, state_nxt;
    logic          win_ext;     // latched winner: 1 = EXT, 0 = CPU
    logic          lat_we;
    logic [AW-1:0] lat_adr;
    logic [DW-1:0] lat_wdata;
    logic [2:0]    lat_cnt;
    logic          any_req;
    logic          tie_ext;     // winner when both ports request
    logic          grant_ext;

    assign any_req   = cpu_req | ext_req;
    assign grant_ext = ext_req & (~cpu_req | tie_ext);

`ifdef MEMARB_RR_EN
    logic last_ext;

    assign tie_ext = ~last_ext;

    // Remember which port won last; reset to EXT so the CPU takes the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            last_ext <= 1'b1;
        else if (state == IDLE && any_req)
            last_ext <= grant_ext;
    end
`else
    logic [3:0] starve_cnt;

    assign tie_ext = (starve_cnt == 4'(STARVE_MAX));

    // Count CPU wins taken while EXT waits; any EXT win or idle EXT clears it.
    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= 4'd0;
        else if (state == IDLE) begin
            if (!ext_req || grant_ext)
                starve_cnt <= 4'd0;
            else if (cpu_req && starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and the per-state strobes; memory sees the latched request.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ack   = 1'b0;
        ext_ack   = 1'b0;
        case (state)
            IDLE:  if (any_req) state_nxt = ISSUE;
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                state_nxt = lat_we ? RESP : WAIT;
            end
            WAIT:  if (lat_cnt == 3'd0) state_nxt = RESP;
            RESP: begin
                cpu_ack   = ~win_ext;
                ext_ack   = win_ext;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_adr   = lat_adr;
    assign mem_wdata = lat_wdata;

    // Request latch, read-latency countdown and per-port read data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_ext   <= 1'b0;
            lat_we    <= 1'b0;
            lat_adr   <= '0;
            lat_wdata <= '0;
            lat_cnt   <= 3'd0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    win_ext   <= grant_ext;
                    lat_we    <= grant_ext ? ext_we    : cpu_we;
                    lat_adr   <= grant_ext ? ext_adr   : cpu_adr;
                    lat_wdata <= grant_ext ? ext_wdata : cpu_wdata;
                end
                ISSUE: lat_cnt <= LAT_INIT;
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        if (win_ext)
                            ext_rdata <= mem_rdata;
                        else
                            cpu_rdata <= mem_rdata;
                    end else
                        lat_cnt <= lat_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance carries most
// scenarios, a MEM_LAT=3 instance checks the longer read latency.
module tb_mem_port_arbiter;
    localparam logic [31:0] BAD = 32'h0BAD0BAD;

    logic        clk = 1'b0;
    logic        reset;
    int          total = 0;
    int          bad   = 0;

    // MEM_LAT=1 instance
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_adr, cpu_wdata, ext_adr, ext_wdata;
    logic [31:0] cpu_rdata, ext_rdata, mem_adr, mem_wdata, mem_rdata;
    logic        cpu_ack, ext_ack, mem_en, mem_we;

    // MEM_LAT=3 instance (EXT side idle)
    logic        cpu3_req, cpu3_we, ext3_req, ext3_we;
    logic [31:0] cpu3_adr, cpu3_wdata, ext3_adr, ext3_wdata;
    logic [31:0] cpu3_rdata, ext3_rdata, mem3_adr, mem3_wdata, mem3_rdata;
    logic        cpu3_ack, ext3_ack, mem3_en, mem3_we;

    // memory model
    logic [31:0] mem [0:255];
    logic [255:0] wr_v;
    logic [31:0] rd1, p1, p2, p3;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ext_req(ext_req), .ext_we(ext_we), .ext_adr(ext_adr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu3_req), .cpu_we(cpu3_we), .cpu_adr(cpu3_adr), .cpu_wdata(cpu3_wdata),
        .cpu_rdata(cpu3_rdata), .cpu_ack(cpu3_ack),
        .ext_req(ext3_req), .ext_we(ext3_we), .ext_adr(ext3_adr), .ext_wdata(ext3_wdata),
        .ext_rdata(ext3_rdata), .ext_ack(ext3_ack),
        .mem_en(mem3_en), .mem_we(mem3_we), .mem_adr(mem3_adr), .mem_wdata(mem3_wdata),
        .mem_rdata(mem3_rdata)
    );

    function automatic logic [31:0] base_val(input logic [7:0] i);
        case (i)
            8'd0:    return 32'h20020005;
            8'd1:    return 32'hA5A50001;
            8'd2:    return 32'hDEADBEEF;
            8'd3:    return 32'h12345678;
            default: return 32'h10000000 | {24'h0, i};
        endcase
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        logic [7:0] i;
        i = a[9:2];
        return wr_v[i] ? mem[i] : base_val(i);
    endfunction

    // Reads return data only in the cycle the latency says; junk otherwise.
    always @(posedge clk) begin
        if (reset)
            wr_v <= '0;
        else if (mem_en && mem_we) begin
            mem[mem_adr[9:2]]  <= mem_wdata;
            wr_v[mem_adr[9:2]] <= 1'b1;
        end
        rd1 <= (mem_en && !mem_we) ? rd_val(mem_adr) : BAD;
        p1  <= (mem3_en && !mem3_we) ? rd_val(mem3_adr) : BAD;
        p2  <= p1;
        p3  <= p2;
    end

    assign mem_rdata  = rd1;
    assign mem3_rdata = p3;

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({cpu_ack, ext_ack, mem_en, mem_we} !== 4'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=0000", {cpu_ack, ext_ack, mem_en, mem_we});
        end
        total++; if ({mem_adr, mem_wdata} !== 64'h0) begin
            bad++; $display("FAIL reset_mem_bus got=%h want=0", {mem_adr, mem_wdata});
        end
        total++; if ({cpu_rdata, ext_rdata} !== 64'h0) begin
            bad++; $display("FAIL reset_rdata got=%h want=0", {cpu_rdata, ext_rdata});
        end
        total++; if ({cpu3_ack, mem3_en, cpu3_rdata} !== 34'h0) begin
            bad++; $display("FAIL reset_dut3 got=%h want=0", {cpu3_ack, mem3_en, cpu3_rdata});
        end
        reset = 1'b0;
    endtask

    task automatic test_cpu_read;
        int en_cnt = 0, ack_cyc = 0, ack_cnt = 0, ext_seen = 0;
        logic [31:0] en_adr = 32'hFFFFFFFF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (mem_en) begin en_cnt++; en_adr = mem_adr; end
            if (ext_ack) ext_seen++;
            if (cpu_ack) begin
                ack_cnt++;
                if (ack_cyc == 0) ack_cyc = c;
                cpu_req = 1'b0;
            end
        end
        total++; if (en_cnt != 1 || en_adr !== 32'h0) begin
            bad++; $display("FAIL cpu_read_en count=%0d adr=%h want 1/00000000", en_cnt, en_adr);
        end
        total++; if (ack_cyc != 3 || ack_cnt != 1) begin
            bad++; $display("FAIL cpu_read_ack cyc=%0d cnt=%0d want 3/1", ack_cyc, ack_cnt);
        end
        total++; if (cpu_rdata !== 32'h20020005) begin
            bad++; $display("FAIL cpu_read_data got=%h want=20020005", cpu_rdata);
        end
        total++; if (ext_seen != 0) begin
            bad++; $display("FAIL cpu_read_no_ext_ack got=%0d want=0", ext_seen);
        end
    endtask

    task automatic test_ext_write;
        int en_cnt = 0, we_cnt = 0, ack_cyc = 0;
        logic [31:0] a = 32'hFFFFFFFF, d = 32'hFFFFFFFF;
        ext_req = 1'b1; ext_we = 1'b1; ext_adr = 32'h54; ext_wdata = 32'h7;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (mem_en) begin en_cnt++; a = mem_adr; d = mem_wdata; end
            if (mem_we) we_cnt++;
            if (ext_ack) begin
                if (ack_cyc == 0) ack_cyc = c;
                ext_req = 1'b0;
            end
        end
        ext_we = 1'b0;
        total++; if (en_cnt != 1 || we_cnt != 1 || a !== 32'h54 || d !== 32'h7) begin
            bad++; $display("FAIL ext_write_bus en=%0d we=%0d adr=%h wdata=%h want 1/1/54/7", en_cnt, we_cnt, a, d);
        end
        total++; if (ack_cyc != 2) begin
            bad++; $display("FAIL ext_write_ack cyc=%0d want=2", ack_cyc);
        end
        total++; if (ext_rdata !== 32'h0 || cpu_rdata !== 32'h20020005) begin
            bad++; $display("FAIL ext_write_rdata_kept ext=%h cpu=%h want 0/20020005", ext_rdata, cpu_rdata);
        end
        ack_cyc = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h54;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin
                if (ack_cyc == 0) ack_cyc = c;
                cpu_req = 1'b0;
            end
        end
        total++; if (ack_cyc != 3 || cpu_rdata !== 32'h7) begin
            bad++; $display("FAIL readback_54 cyc=%0d data=%h want 3/00000007", ack_cyc, cpu_rdata);
        end
    endtask

    task automatic test_arbitration;
        int ord [8];
        int cyc [8];
        int exp_ord [6];
        int n = 0;
`ifdef MEMARB_RR_EN
        exp_ord = '{0, 1, 0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 0, 0, 1, 0};
`endif
        // fresh reset so both the starvation count and round-robin pointer start clean
        test_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0;
        ext_req = 1'b1; ext_we = 1'b0; ext_adr = 32'h4;
        for (int c = 1; c <= 60 && n < 6; c++) begin
            @(posedge clk); #1;
            if (cpu_ack && n < 8) begin ord[n] = 0; cyc[n] = c; n++; end
            if (ext_ack && n < 8) begin ord[n] = 1; cyc[n] = c; n++; end
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        @(posedge clk); #1;
        total++; if (n < 6) begin
            bad++; $display("FAIL arb_timeout grants=%0d want=6", n);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++; if (ord[i] != exp_ord[i]) begin
                    bad++; $display("FAIL arb_order[%0d] got=%0d want=%0d (0=cpu 1=ext)", i, ord[i], exp_ord[i]);
                end
            end
            total++; if (cyc[0] != 3 || cyc[1] - cyc[0] != 4) begin
                bad++; $display("FAIL arb_throughput first=%0d gap=%0d want 3/4", cyc[0], cyc[1] - cyc[0]);
            end
        end
    endtask

    task automatic test_lat3;
        int ack_cyc = 0, ack_cnt = 0;
        logic [15:0] en_mask = '0;
        cpu3_req = 1'b1; cpu3_we = 1'b0; cpu3_adr = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (mem3_en) en_mask[c] = 1'b1;
            if (cpu3_ack) begin
                ack_cnt++;
                if (ack_cyc == 0) ack_cyc = c;
                cpu3_req = 1'b0;
            end
        end
        total++; if (en_mask !== 16'h0002) begin
            bad++; $display("FAIL lat3_en_cycles got=%h want=0002", en_mask);
        end
        total++; if (ack_cyc != 5 || ack_cnt != 1) begin
            bad++; $display("FAIL lat3_ack cyc=%0d cnt=%0d want 5/1", ack_cyc, ack_cnt);
        end
        total++; if (cpu3_rdata !== 32'h20020005) begin
            bad++; $display("FAIL lat3_data got=%h want=20020005", cpu3_rdata);
        end
    endtask

    task automatic test_reset_mid;
        int ack_cyc = 0, early_ack = 0;
        ext_req = 1'b1; ext_we = 1'b0; ext_adr = 32'h8;
        @(posedge clk); #1;
        total++; if (mem_en !== 1'b1 || mem_adr !== 32'h8) begin
            bad++; $display("FAIL rmid_issue en=%b adr=%h want 1/8", mem_en, mem_adr);
        end
        @(posedge clk); #1;
        if (ext_ack) early_ack++;
        reset = 1'b1;
        @(posedge clk); #1;
        if (ext_ack) early_ack++;
        total++; if ({cpu_ack, ext_ack, mem_en, mem_we} !== 4'b0 || {mem_adr, mem_wdata} !== 64'h0) begin
            bad++; $display("FAIL rmid_outputs strobes=%b bus=%h want 0", {cpu_ack, ext_ack, mem_en, mem_we}, {mem_adr, mem_wdata});
        end
        total++; if (ext_rdata !== 32'h0 || cpu_rdata !== 32'h0) begin
            bad++; $display("FAIL rmid_rdata ext=%h cpu=%h want 0/0", ext_rdata, cpu_rdata);
        end
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ext_ack) begin
                if (ack_cyc == 0) ack_cyc = c;
                ext_req = 1'b0;
            end
        end
        total++; if (early_ack != 0) begin
            bad++; $display("FAIL rmid_dropped_ack got=%0d want=0", early_ack);
        end
        total++; if (ack_cyc != 3 || ext_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rmid_reissue cyc=%0d data=%h want 3/deadbeef", ack_cyc, ext_rdata);
        end
    endtask

    task automatic test_rdata_hold;
        int ack_cyc = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'hC;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin
                if (ack_cyc == 0) ack_cyc = c;
                cpu_req = 1'b0;
            end
        end
        total++; if (ack_cyc != 3 || cpu_rdata !== 32'h12345678) begin
            bad++; $display("FAIL hold_cpu cyc=%0d data=%h want 3/12345678", ack_cyc, cpu_rdata);
        end
        total++; if (ext_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL hold_ext got=%h want=deadbeef", ext_rdata);
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_adr = '0; ext_wdata = '0;
        cpu3_req = 1'b0; cpu3_we = 1'b0; cpu3_adr = '0; cpu3_wdata = '0;
        ext3_req = 1'b0; ext3_we = 1'b0; ext3_adr = '0; ext3_wdata = '0;
        test_reset();
        test_cpu_read();
        test_ext_write();
        test_arbitration();
        test_lat3();
        test_reset_mid();
        test_rdata_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
